// File: rtl/fir_axil_cfg.sv
// AXI-Lite responder and configuration register file for the FIR engine.
// Holds ctrl/status and data_length, and arbitrates the tap BRAM between host and engine.
module fir_axil_cfg #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  input  logic [pADDR_WIDTH-1:0] core_tap_A,
  output logic                   ap_start_o,
  input  logic                   ap_done_i,
  output logic [31:0]            data_length
);

  localparam logic [pADDR_WIDTH-1:0] CTRL_ADDR = '0;
  localparam logic [pADDR_WIDTH-1:0] LEN_ADDR  = pADDR_WIDTH'(16);
  localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(32);
  localparam logic [pADDR_WIDTH-1:0] TAP_END   = pADDR_WIDTH'(32 + 4 * Tape_Num);

  typedef enum logic [2:0] {A_IDLE, WR_ACK, RD_ADDR, RD_WAIT, RD_DATA} axi_state_t;

  axi_state_t             state;
  logic [pADDR_WIDTH-1:0] rd_addr;
  logic                   ap_start, ap_done, ap_idle;
  logic                   h_tap_en;
  logic [3:0]             h_tap_we;
  logic [pADDR_WIDTH-1:0] h_tap_a;
  logic [pDATA_WIDTH-1:0] h_tap_di;
  logic [pDATA_WIDTH-1:0] rd_value;
  logic                   host_owns_bram;

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a >= TAP_BASE) && (a < TAP_END) && (a[1:0] == 2'b00);
  endfunction

  // ap_start already pending means the engine takes the BRAM on the next edge
  assign host_owns_bram = ap_idle && !ap_start;

  always_comb begin
    tap_A  = ap_idle ? h_tap_a  : core_tap_A;
    tap_EN = ap_idle ? h_tap_en : 1'b1;
    tap_WE = ap_idle ? h_tap_we : 4'h0;
    tap_Di = h_tap_di;
  end

  always_comb begin
    rd_value = '0;
    if (is_tap(rd_addr))
      rd_value = ap_idle ? tap_Do : '1;
    else if (rd_addr == CTRL_ADDR)
      rd_value = pDATA_WIDTH'({ap_idle, ap_done, ap_start});
    else if (rd_addr == LEN_ADDR)
      rd_value = pDATA_WIDTH'(data_length);
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state       <= A_IDLE;
      awready     <= 1'b0;
      wready      <= 1'b0;
      arready     <= 1'b0;
      rvalid      <= 1'b0;
      rdata       <= '0;
      rd_addr     <= '0;
      ap_start    <= 1'b0;
      ap_done     <= 1'b0;
      ap_idle     <= 1'b1;
      ap_start_o  <= 1'b0;
      data_length <= '0;
      h_tap_en    <= 1'b0;
      h_tap_we    <= '0;
      h_tap_a     <= '0;
      h_tap_di    <= '0;
    end else begin
      awready    <= 1'b0;
      wready     <= 1'b0;
      arready    <= 1'b0;
      h_tap_en   <= 1'b0;
      h_tap_we   <= '0;
      ap_start_o <= 1'b0;

      if (ap_start) begin
        ap_start   <= 1'b0;
        ap_idle    <= 1'b0;
        ap_start_o <= 1'b1;
      end

      case (state)
        A_IDLE: begin
          if (awvalid && wvalid) begin
            state   <= WR_ACK;
            awready <= 1'b1;
            wready  <= 1'b1;
            // BRAM strobes go out during the ack cycle so the tap lands on the commit edge
            if (host_owns_bram && is_tap(awaddr)) begin
              h_tap_en <= 1'b1;
              h_tap_we <= 4'hF;
              h_tap_a  <= awaddr - TAP_BASE;
              h_tap_di <= wdata;
            end
          end else if (arvalid) begin
            state   <= RD_ADDR;
            arready <= 1'b1;
            rd_addr <= araddr;
            if (host_owns_bram && is_tap(araddr)) begin
              h_tap_en <= 1'b1;
              h_tap_a  <= araddr - TAP_BASE;
            end
          end
        end
        WR_ACK: begin
          state <= A_IDLE;
          if (host_owns_bram && awaddr == CTRL_ADDR && wdata[0])
            ap_start <= 1'b1;
          if (ap_idle && awaddr == LEN_ADDR)
            data_length <= 32'(wdata);
        end
        RD_ADDR: state <= RD_WAIT;
        RD_WAIT: begin
          state  <= RD_DATA;
          rvalid <= 1'b1;
          rdata  <= rd_value;
        end
        RD_DATA: begin
          if (rready) begin
            state  <= A_IDLE;
            rvalid <= 1'b0;
            if (rd_addr == CTRL_ADDR) ap_done <= 1'b0;
          end
        end
        default: state <= A_IDLE;
      endcase

      // Engine completion overrides both the start clear and the read clear
      if (ap_done_i) begin
        ap_done <= 1'b1;
        ap_idle <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_axil_cfg.sv
// Self-checking bench for fir_axil_cfg: vector table, randomized traffic against a
// register-map model, and hand sequences for busy, done, collision and reset cases.
module tb_fir_axil_cfg;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n;
  logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [11:0] awaddr, araddr, tap_A, core_tap_A;
  logic [31:0] wdata, rdata, tap_Di, tap_Do, data_length;
  logic [3:0]  tap_WE;
  logic        tap_EN, ap_start_o, ap_done_i;

  fir_axil_cfg #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(11)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
    .core_tap_A(core_tap_A), .ap_start_o(ap_start_o), .ap_done_i(ap_done_i),
    .data_length(data_length)
  );

  always #5 axis_clk = ~axis_clk;

  // Tap BRAM: byte-enabled, read-first, one-cycle read latency
  logic [31:0] bram [0:1023];
  always @(posedge axis_clk) begin
    if (tap_EN) begin
      for (int b = 0; b < 4; b++)
        if (tap_WE[b]) bram[tap_A[11:2]][8*b +: 8] <= tap_Di[8*b +: 8];
      tap_Do <= bram[tap_A[11:2]];
    end
  end

  int we_count = 0;
  int start_count = 0;
  always @(posedge axis_clk) begin
    if (tap_EN && tap_WE != 4'h0) we_count <= we_count + 1;
    if (ap_start_o) start_count <= start_count + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, output int lat);
    int n;
    n = 0;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    do begin @(posedge axis_clk); #1; n++; end while (!(awready && wready) && n < 50);
    lat = n;
    @(posedge axis_clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, input bit done_at_accept,
                          output logic [31:0] d, output int lat);
    int n;
    n = 0;
    araddr = a; arvalid = 1'b1;
    do begin @(posedge axis_clk); #1; n++; end while (!arready && n < 50);
    @(posedge axis_clk); #1; n++;
    arvalid = 1'b0;
    while (!rvalid && n < 50) begin @(posedge axis_clk); #1; n++; end
    d = rdata; lat = n;
    if (done_at_accept) ap_done_i = 1'b1;
    @(posedge axis_clk); #1;
    ap_done_i = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
  } vec_t;

  vec_t        tbl[$];
  int          tapv[11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
  logic [31:0] taps_m[11];
  logic [31:0] len_m;
  bit          done_m;
  logic [11:0] unm[6] = '{12'h004, 12'h014, 12'h01C, 12'h04C, 12'h022, 12'h200};

  function automatic logic [31:0] ref_read(input logic [11:0] a);
    int ai;
    ai = int'(a);
    if (ai == 0) return {29'd0, 1'b1, done_m, 1'b0};
    if (ai == 16) return len_m;
    if (ai >= 32 && ai < 32 + 4 * 11 && ai % 4 == 0) return taps_m[(ai - 32) / 4];
    return 32'd0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int lat, we0;
    awvalid = 0; wvalid = 0; arvalid = 0; rready = 1; ap_done_i = 0;
    awaddr = '0; araddr = '0; wdata = '0; core_tap_A = 12'h01C;
    axis_rst_n = 0;
    repeat (3) @(posedge axis_clk);
    #1 axis_rst_n = 1;
    @(posedge axis_clk); #1;

    chk("rst_ready", {29'd0, awready, wready, arready}, 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_start_o", 32'(ap_start_o), 32'd0);
    chk("rst_tap_en_we", {27'd0, tap_EN, tap_WE}, 32'd0);
    chk("rst_tap_a", 32'(tap_A), 32'd0);
    chk("rst_tap_di", tap_Di, 32'd0);
    chk("rst_len", data_length, 32'd0);

    tbl.push_back('{0, 12'h000, 32'h4});
    tbl.push_back('{0, 12'h010, 32'd0});
    tbl.push_back('{1, 12'h010, 32'd600});
    for (int k = 0; k < 11; k++) tbl.push_back('{1, 12'(32 + 4 * k), 32'(tapv[k])});
    tbl.push_back('{0, 12'h010, 32'd600});
    for (int k = 0; k < 11; k++) tbl.push_back('{0, 12'(32 + 4 * k), 32'(tapv[k])});
    tbl.push_back('{0, 12'h04C, 32'd0});

    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        axi_write(tbl[i].addr, tbl[i].data, lat);
        chk($sformatf("wr_lat_%0h", tbl[i].addr), 32'(lat), 32'd1);
      end else begin
        axi_read(tbl[i].addr, 1'b0, d, lat);
        chk($sformatf("rd_%0h", tbl[i].addr), d, tbl[i].data);
        chk($sformatf("rd_lat_%0h", tbl[i].addr), 32'(lat), 32'd3);
      end
    end
    chk("len_port", data_length, 32'd600);

    for (int k = 0; k < 11; k++) taps_m[k] = 32'(tapv[k]);
    len_m = 32'd600; done_m = 0;
    for (int i = 0; i < 40; i++) begin
      int sel;
      logic [11:0] a;
      logic [31:0] v;
      sel = int'($urandom_range(0, 8));
      if (sel <= 5) a = 12'(32 + 4 * int'($urandom_range(0, 10)));
      else if (sel == 6) a = 12'h010;
      else if (sel == 7) a = unm[$urandom_range(0, 5)];
      else a = 12'h000;
      if (a != 12'h000 && $urandom_range(0, 1) == 1) begin
        v = $urandom;
        axi_write(a, v, lat);
        if (a == 12'h010) len_m = v;
        else if (int'(a) >= 32 && int'(a) < 76 && a[1:0] == 2'b00) taps_m[(int'(a) - 32) / 4] = v;
      end else begin
        axi_read(a, 1'b0, d, lat);
        chk($sformatf("rand_rd_%0h", a), d, ref_read(a));
      end
    end
    axi_write(12'h010, 32'd600, lat);
    axi_write(12'h024, 32'hFFFFFFF6, lat);

    axi_write(12'h000, 32'd1, lat);
    chk("start_o_pre", 32'(ap_start_o), 32'd0);
    @(posedge axis_clk); #1;
    chk("start_o_pulse", 32'(ap_start_o), 32'd1);
    chk("busy_tap_a", 32'(tap_A), 32'h01C);
    chk("busy_tap_en_we", {27'd0, tap_EN, tap_WE}, 32'h10);
    @(posedge axis_clk); #1;
    chk("start_o_end", 32'(ap_start_o), 32'd0);

    axi_read(12'h000, 1'b0, d, lat);
    chk("busy_ctrl", d & 32'hF, 32'd0);
    we0 = we_count;
    axi_write(12'h024, 32'd99, lat);
    axi_write(12'h010, 32'd5, lat);
    axi_write(12'h000, 32'd1, lat);
    repeat (2) @(posedge axis_clk); #1;
    chk("busy_no_we", 32'(we_count), 32'(we0));
    chk("busy_one_start", 32'(start_count), 32'd1);
    axi_read(12'h024, 1'b0, d, lat);
    chk("busy_tap_rd", d, 32'hFFFFFFFF);
    axi_read(12'h010, 1'b0, d, lat);
    chk("busy_len_rd", d, 32'd600);

    ap_done_i = 1;
    @(posedge axis_clk); #1;
    ap_done_i = 0;
    axi_read(12'h000, 1'b0, d, lat);
    chk("done_first", d, 32'h6);
    axi_read(12'h000, 1'b0, d, lat);
    chk("done_cleared", d, 32'h4);
    axi_read(12'h024, 1'b0, d, lat);
    chk("tap1_after_done", d, 32'hFFFFFFF6);

    axi_read(12'h000, 1'b1, d, lat);
    chk("done_collide_rd", d, 32'h4);
    axi_read(12'h000, 1'b0, d, lat);
    chk("done_set_wins", d, 32'h6);
    axi_read(12'h000, 1'b0, d, lat);
    chk("done_reclear", d, 32'h4);

    we0 = we_count;
    awaddr = 12'h048; wdata = 32'h1234; araddr = 12'h048;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(posedge axis_clk); #1;
    chk("coll_wr_first", {30'd0, awready, arready}, 32'h2);
    @(posedge axis_clk); #1;
    awvalid = 0; wvalid = 0;
    chk("coll_ack_1cyc", 32'(awready), 32'd0);
    @(posedge axis_clk); #1;
    chk("coll_rd_accept", 32'(arready), 32'd1);
    @(posedge axis_clk); #1;
    arvalid = 0; rready = 0;
    @(posedge axis_clk); #1;
    chk("coll_rvalid", 32'(rvalid), 32'd1);
    chk("coll_rdata", rdata, 32'h1234);
    repeat (2) @(posedge axis_clk); #1;
    chk("hold_rvalid", 32'(rvalid), 32'd1);
    chk("hold_rdata", rdata, 32'h1234);
    rready = 1;
    @(posedge axis_clk); #1;
    chk("rd_release", 32'(rvalid), 32'd0);
    chk("coll_one_commit", 32'(we_count), 32'(we0 + 1));

    araddr = 12'h010; arvalid = 1;
    @(posedge axis_clk); #1;
    arvalid = 0; axis_rst_n = 0;
    @(posedge axis_clk); #1;
    chk("mid_rst_rvalid", {30'd0, rvalid, arready}, 32'd0);
    chk("mid_rst_len", data_length, 32'd0);
    axis_rst_n = 1;
    repeat (3) @(posedge axis_clk); #1;
    chk("mid_rst_no_rvalid", 32'(rvalid), 32'd0);
    axi_read(12'h010, 1'b0, d, lat);
    chk("post_rst_len", d, 32'd0);
    axi_read(12'h000, 1'b0, d, lat);
    chk("post_rst_ctrl", d, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_axil_cfg.md
# fir_axil_cfg

AXI-Lite responder and configuration register file for the FIR engine. It accepts the host's AXI-Lite write and read transactions and holds the control/status word and the data length. It owns the tap-coefficient BRAM port, arbitrating it between host access when idle and engine access when running. It sits between the AXI-Lite bus and the FIR datapath, and drives the engine's start pulse.

## Interface
Parameters:
- pADDR_WIDTH, 12, AXI-Lite and BRAM address width
- pDATA_WIDTH, 32, data width
- Tape_Num, 11, number of tap coefficients

Ports:
- axis_clk  in  1  the only clock; all logic on rising edge
- axis_rst_n  in  1  reset; synchronous and active-low
- awvalid / awready  in / out  1 / 1  write-address handshake
- awaddr  in  pADDR_WIDTH  write byte address
- wvalid / wready  in / out  1 / 1  write-data handshake
- wdata  in  pDATA_WIDTH  write data
- arvalid / arready  in / out  1 / 1  read-address handshake
- araddr  in  pADDR_WIDTH  read byte address
- rvalid / rready  out / in  1 / 1  read-data handshake
- rdata  out  pDATA_WIDTH  read data
- tap_WE  out  4  tap BRAM byte write enables
- tap_EN  out  1  tap BRAM enable
- tap_Di  out  pDATA_WIDTH  tap BRAM write data
- tap_A  out  pADDR_WIDTH  tap BRAM byte address; 1-cycle read latency
- tap_Do  in  pDATA_WIDTH  tap BRAM read data
- core_tap_A  in  pADDR_WIDTH  engine tap read address, used while busy
- ap_start_o  out  1  one-cycle start pulse to the engine
- ap_done_i  in  1  one-cycle pulse from the engine after the last output is accepted
- data_length  out  32  programmed sample count

## Operation
- Register map, by byte address:
  - 0x00: ctrl. bit0 ap_start (write 1 to set), bit1 ap_done, bit2 ap_idle; all other bits read 0.
  - 0x10: data_length (read/write).
  - 0x20+4k, k=0..10: tap k, stored in the BRAM at tap_A = addr-0x20.
  - Unmapped addresses: writes are ignored; reads return 0.
- ap_start write:
  - A write of 0x00 with wdata[0]=1 while ap_idle=1 sets ap_start.
  - On the next cycle the block clears ap_start and ap_idle, and pulses ap_start_o for one cycle.
  - A write of ap_start while busy is ignored.
- ap_done_i: sets ap_done and ap_idle.
- ap_done is clear-on-read. A read of 0x00 returns the current value, then clears bit1 when the read data is accepted.
- Busy (ap_idle=0):
  - tap_A = core_tap_A, tap_EN=1, tap_WE=0.
  - Host tap writes and data_length writes complete the handshake but are dropped.
  - Host tap reads return 0xFFFFFFFF.
- Idle: tap_EN and tap_A are driven by the host transaction only; tap_WE=4'hF on a tap write.
- AXI FSM states:
  - A_IDLE: if awvalid and wvalid, go to WR_ACK; else if arvalid, go to RD_ADDR. Writes have priority.
  - WR_ACK: assert awready and wready for one cycle, commit the write, return to A_IDLE.
  - RD_ADDR: assert arready, latch araddr, issue the BRAM read if the address is a tap; go to RD_WAIT.
  - RD_WAIT: capture tap_Do or the register value into rdata; go to RD_DATA.
  - RD_DATA: hold rvalid=1 and a stable rdata until rready; then return to A_IDLE.
- There is no write-response channel.

## Timing
- Reset values: awready=wready=arready=rvalid=0, rdata=0, ap_start=0, ap_done=0, ap_idle=1, data_length=0, ap_start_o=0, tap_EN=0, tap_WE=0, tap_A=0, tap_Di=0.
- Write: both valids are sampled high at edge N; awready and wready are high during cycle N+1; the register or BRAM commits at edge N+2. The handshake ready pulse is exactly one cycle.
- Read: arvalid is sampled at edge N; arready is high during cycle N+1; rvalid rises during cycle N+3. Minimum latency is 3 cycles.
- A read and a write arriving in the same cycle: the write is served first, and the read is accepted the cycle after the FSM returns to A_IDLE.
- ap_done_i in the same cycle as a read of 0x00 accepts: ap_done stays set, because the set wins over the clear.
- ap_done_i while idle: ap_done is set and ap_idle stays 1.
- Reset asserted mid-transaction: the FSM returns to A_IDLE, any pending read is dropped with rvalid=0, and all registers take their reset values at that edge.

## Test plan
- Reset, then read 0x00 -> rdata=0x4; read 0x10 -> rdata=0.
- Write 0x10=600, write taps {0,-10,-9,23,56,63,56,23,-9,-10,0}, then read all taps back -> every value matches, and each read's rvalid rises 3 cycles after arvalid is sampled.
- Write 0x00=1 -> ap_start_o pulses once the cycle after the commit; a subsequent read of 0x00 -> (rdata & 0xF) = 0.
- While busy: write tap 0x24=99 and write 0x10=5, then read 0x24 -> 0xFFFFFFFF, and read 0x10 -> 600. After done, read 0x24 -> -10.
- Pulse ap_done_i -> first read of 0x00 gives 0x6; a second read gives 0x4.
- Hold awvalid, wvalid and arvalid high together -> the write completes first, the read follows, and only one write commit occurs.
